// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one 8N1 UART transmitter among NUM_REQ requesters.
// Define UART_TX_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD_RATE  = 1156000,
  parameter int GAP_CYCLES = 4
) (
  input  logic                          t_clk,
  input  logic                          t_rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            done,
  output logic                          tx_valid,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          busy
);

  localparam int BAUD_DIV     = (CLOCK_FREQ + BAUD_RATE/2) / BAUD_RATE;
  localparam int BIT_CYCLES   = BAUD_DIV + 1;
  // start + data + stop + one guard bit
  localparam int FRAME_CYCLES = BIT_CYCLES * (DATA_WIDTH + 3);
  localparam int CNT_W        = $clog2(FRAME_CYCLES);
  localparam int IDX_W        = $clog2(NUM_REQ);

  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [CNT_W-1:0]        r_cnt;
  logic [NUM_REQ-1:0]      r_gnt;
  logic [NUM_REQ-1:0]      r_done;
  logic                    r_tx_valid;
  logic [DATA_WIDTH-1:0]   r_tx_data;
  logic                    r_busy;

  logic                    w_any;
  logic [IDX_W-1:0]        w_win;
  logic [IDX_W-1:0]        w_k;
  logic [NUM_REQ-1:0]      w_onehot;
  logic                    w_grant;
  logic                    w_frame_end;
  logic                    w_gap_end;

`ifndef UART_TX_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0]        r_ptr;
  logic [IDX_W-1:0]        w_ptr_nxt;
`endif

  // First set request searching upward from the pointer (or from 0).
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_k   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
`ifdef UART_TX_ARB_FIXED_PRIO_EN
      w_k = IDX_W'(i);
`else
      w_k = IDX_W'((int'(r_ptr) + i) % NUM_REQ);
`endif
      if (!w_any && req[w_k]) begin
        w_any = 1'b1;
        w_win = w_k;
      end
    end
  end

  assign w_onehot = NUM_REQ'(1) << w_win;

`ifndef UART_TX_ARB_FIXED_PRIO_EN
  assign w_ptr_nxt = (w_win == IDX_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_frame_end = 1'b0;
    w_gap_end   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_grant     = 1'b1;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        if (r_cnt == FRAME_LAST) begin
          w_frame_end = 1'b1;
          w_state_nxt = GAP;
        end
      end
      GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_gap_end   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge t_clk or negedge t_rst) begin
    if (!t_rst) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge t_clk or negedge t_rst) begin
    if (!t_rst) begin
      r_cnt      <= '0;
      r_gnt      <= '0;
      r_done     <= '0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_done <= '0;
      r_busy <= (w_state_nxt != IDLE);
      if (w_grant) begin
        r_gnt      <= w_onehot;
        r_tx_data  <= req_data[w_win*DATA_WIDTH +: DATA_WIDTH];
        r_tx_valid <= 1'b1;
        r_cnt      <= '0;
      end else if (w_frame_end) begin
        r_gnt      <= '0;
        r_done     <= r_gnt;
        r_tx_valid <= 1'b0;
        r_cnt      <= '0;
      end else if (w_gap_end) begin
        r_cnt <= '0;
      end else if (r_state != IDLE) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

`ifndef UART_TX_ARB_FIXED_PRIO_EN
  always_ff @(posedge t_clk or negedge t_rst) begin
    if (!t_rst)       r_ptr <= '0;
    else if (w_grant) r_ptr <= w_ptr_nxt;
  end
`endif

  assign gnt      = r_gnt;
  assign done     = r_done;
  assign tx_valid = r_tx_valid;
  assign tx_data  = r_tx_data;
  assign busy     = r_busy;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: vector table for grants and frame timing,
// plus sequences for arbitration order, withdrawal, data hold and reset abort.
module tb_uart_tx_arbiter;

  localparam int FRAME = 484;
  localparam int GAPC  = 4;

  logic        t_clk;
  logic        t_rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  uart_tx_arbiter dut (
    .t_clk    (t_clk),
    .t_rst    (t_rst),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .done     (done),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .busy     (busy)
  );

  initial t_clk = 1'b0;
  always #5 t_clk = ~t_clk;
  always @(posedge t_clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  gnt;
    logic [7:0]  byt;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge t_clk);
    t_rst = 1'b0;
    req   = '0;
    repeat (3) @(negedge t_clk);
    t_rst = 1'b1;
  endtask

  task automatic wait_gnt(input int limit);
    int c;
    c = 0;
    while (gnt == '0 && c < limit) begin
      @(negedge t_clk);
      c++;
    end
    if (gnt == '0) begin
      checks++;
      errors++;
      $display("FAIL gnt_timeout: no grant within %0d cycles", limit);
    end
  endtask

  task automatic run_frame(input logic [7:0] exp_byte, input int act_at,
                           input logic [3:0] nreq, input logic [31:0] ndata,
                           output int len, output int bad);
    len = 0;
    bad = 0;
    while (tx_valid === 1'b1 && len < 2000) begin
      if (tx_data !== exp_byte) bad++;
      if (len == act_at) begin
        req      = nreq;
        req_data = ndata;
      end
      @(negedge t_clk);
      len++;
    end
  endtask

  logic [3:0] fair_g[5];
  logic [7:0] fair_b[5];

  initial begin
    int len, bad, n, low, t0, g;
    logic [3:0] dacc;

    vecs[0] = '{4'b0001, 32'h443322A5, 4'b0001, 8'hA5};
    vecs[1] = '{4'b0100, 32'h44332211, 4'b0100, 8'h33};
    vecs[2] = '{4'b1000, 32'h44332211, 4'b1000, 8'h44};
    vecs[3] = '{4'b0110, 32'h44332211, 4'b0010, 8'h22};
    vecs[4] = '{4'b1111, 32'h5A6B7C8D, 4'b0001, 8'h8D};
    vecs[5] = '{4'b1100, 32'h44332211, 4'b0100, 8'h33};

`ifdef UART_TX_ARB_FIXED_PRIO_EN
    fair_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    fair_b = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h11};
`else
    fair_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    fair_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
`endif

    t_rst    = 1'b0;
    req      = '0;
    req_data = '0;
    repeat (2) @(negedge t_clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_busy", 32'(busy), 0);

    for (int v = 0; v < 6; v++) begin
      do_reset();
      req      = vecs[v].req;
      req_data = vecs[v].data;
      @(negedge t_clk);
      chk("vec_gnt", 32'(gnt), 32'(vecs[v].gnt));
      chk("vec_tx_data", 32'(tx_data), 32'(vecs[v].byt));
      chk("vec_busy", 32'(busy), 1);
      req = '0;
      run_frame(vecs[v].byt, -1, '0, '0, len, bad);
      chk("vec_frame_len", len, FRAME);
      chk("vec_data_hold", bad, 0);
      chk("vec_done", 32'(done), 32'(vecs[v].gnt));
      n = 0;
      do begin
        @(negedge t_clk);
        n++;
        if (n == 1) chk("vec_done_1cyc", 32'(done), 0);
      end while (busy && n < 20);
      chk("vec_busy_tail", n, GAPC);
    end

    // Two simultaneous requests: 0 then 2, fixed spacing between starts.
    do_reset();
    req      = 4'b0101;
    req_data = 32'h44332211;
    @(negedge t_clk);
    t0 = cyc;
    chk("sim_gnt0", 32'(gnt), 32'b0001);
    req = 4'b0100;
    run_frame(8'h11, -1, 4'b0100, 32'h44332211, len, bad);
    chk("sim_len0", len, FRAME);
    low = 0;
    while (!tx_valid && low < 50) begin
      low++;
      @(negedge t_clk);
    end
    chk("sim_low_len", low, GAPC + 1);
    chk("sim_gnt2", 32'(gnt), 32'b0100);
    chk("sim_tx_data2", 32'(tx_data), 32'h33);
    chk("sim_spacing", cyc - t0, FRAME + GAPC + 1);
    req = '0;

    // Everyone requesting continuously.
    do_reset();
    req      = 4'b1111;
    req_data = 32'h44332211;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(20);
      chk("fair_gnt", 32'(gnt), 32'(fair_g[k]));
      chk("fair_tx_data", 32'(tx_data), 32'(fair_b[k]));
      run_frame(fair_b[k], -1, 4'b1111, 32'h44332211, len, bad);
      chk("fair_len", len, FRAME);
    end
    req = '0;

    // Requester 1 withdraws mid-frame.
    do_reset();
    req      = 4'b0010;
    req_data = 32'h44332211;
    @(negedge t_clk);
    chk("wd_gnt", 32'(gnt), 32'b0010);
    run_frame(8'h22, 100, 4'b0000, 32'h44332211, len, bad);
    chk("wd_len", len, FRAME);
    chk("wd_done", 32'(done), 32'b0010);
    g = 0;
    repeat (20) begin
      @(negedge t_clk);
      if (gnt != '0 || tx_valid) g++;
    end
    chk("wd_no_regrant", g, 0);

    // Requester data changes mid-frame; new byte only at next grant.
    do_reset();
    req      = 4'b0001;
    req_data = 32'h44332211;
    @(negedge t_clk);
    chk("ds_gnt", 32'(gnt), 32'b0001);
    run_frame(8'h11, 50, 4'b0001, 32'h443322FF, len, bad);
    chk("ds_hold", bad, 0);
    chk("ds_len", len, FRAME);
    wait_gnt(20);
    chk("ds_gnt2", 32'(gnt), 32'b0001);
    chk("ds_tx_data2", 32'(tx_data), 32'hFF);
    req = '0;

    // Asynchronous reset mid-frame.
    do_reset();
    req      = 4'b0100;
    req_data = 32'h44332211;
    @(negedge t_clk);
    chk("ra_gnt", 32'(gnt), 32'b0100);
    req = '0;
    repeat (200) @(negedge t_clk);
    #2 t_rst = 1'b0;
    #1;
    chk("ra_tx_valid", 32'(tx_valid), 0);
    chk("ra_gnt_clr", 32'(gnt), 0);
    chk("ra_busy", 32'(busy), 0);
    dacc = done;
    repeat (4) begin
      @(negedge t_clk);
      dacc |= done;
    end
    chk("ra_no_done", 32'(dacc), 0);
    t_rst    = 1'b1;
    req      = 4'b1010;
    @(negedge t_clk);
    chk("ra_regrant", 32'(gnt), 32'b0010);
    chk("ra_tx_data", 32'(tx_data), 32'h22);
    req = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
